mem_port_arbiter: RTL and testbench

MEM_PORT_ARBITER -- requirements
Module: mem_port_arbiter

---
 rtl/mem_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Two-requester arbiter for a single-ported memory with fixed read latency; one command in flight.
// Define MEMARB_RR_EN for round-robin arbitration; otherwise requester 0 has fixed priority.
module mem_port_arbiter #(
    parameter int W      = 32,
    parameter int ADDR_W = 32,
    parameter int RD_LAT = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              m0_valid,
    input  logic              m0_we,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [W-1:0]      m0_wdata,
    output logic              m0_ready,
    output logic              m0_rvalid,
    output logic [W-1:0]      m0_rdata,
    input  logic              m1_valid,
    input  logic              m1_we,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [W-1:0]      m1_wdata,
    output logic              m1_ready,
    output logic              m1_rvalid,
    output logic [W-1:0]      m1_rdata,
    output logic              read,
    output logic              write,
    output logic [ADDR_W-1:0] readaddress,
    output logic [ADDR_W-1:0] writeaddress,
    output logic [W-1:0]      writedata,
    input  logic [W-1:0]      readdata,
    output logic              busy
);

    typedef enum logic {
        IDLE    = 1'b0,
        RD_WAIT = 1'b1
    } state_t;

    localparam logic [3:0] RD_LAT_C = 4'(RD_LAT);

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic              owner_q, owner_d;
    logic              elig0, elig1, sel, sel_we;
    logic [ADDR_W-1:0] sel_addr;
    logic [W-1:0]      sel_wdata;

    logic              read_d, write_d, ready0_d, ready1_d, rvalid0_d, rvalid1_d;
    logic [W-1:0]      rdata0_d, rdata1_d, wdata_d;
    logic [ADDR_W-1:0] raddr_d, waddr_d;

`ifdef MEMARB_RR_EN
    logic              last_q, last_d;
`endif

    // A requester still shows valid during its ready cycle; it must not be re-accepted then.
    assign elig0 = m0_valid & ~m0_ready;
    assign elig1 = m1_valid & ~m1_ready;

`ifdef MEMARB_RR_EN
    assign sel = (elig0 && elig1) ? ~last_q : elig1;
`else
    assign sel = ~elig0;
`endif

    assign sel_we    = sel ? m1_we    : m0_we;
    assign sel_addr  = sel ? m1_addr  : m0_addr;
    assign sel_wdata = sel ? m1_wdata : m0_wdata;
    assign busy      = (state_q != IDLE);

    always_comb begin
        // NOTE: every output of this block gets a default first so no latch is inferred.
        state_d   = state_q;
        cnt_d     = cnt_q;
        owner_d   = owner_q;
        read_d    = 1'b0;
        write_d   = 1'b0;
        ready0_d  = 1'b0;
        ready1_d  = 1'b0;
        rvalid0_d = 1'b0;
        rvalid1_d = 1'b0;
        rdata0_d  = m0_rdata;
        rdata1_d  = m1_rdata;
        raddr_d   = readaddress;
        waddr_d   = writeaddress;
        wdata_d   = writedata;
`ifdef MEMARB_RR_EN
        last_d    = last_q;
`endif
        case (state_q)
            IDLE: begin
                if (elig0 || elig1) begin
                    ready0_d = ~sel;
                    ready1_d = sel;
`ifdef MEMARB_RR_EN
                    last_d   = sel;
`endif
                    if (sel_we) begin
                        write_d = 1'b1;
                        waddr_d = sel_addr;
                        wdata_d = sel_wdata;
                    end else begin
                        read_d  = 1'b1;
                        raddr_d = sel_addr;
                        state_d = RD_WAIT;
                        cnt_d   = RD_LAT_C;
                        owner_d = sel;
                    end
                end
            end
            RD_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = IDLE;
                    if (owner_q) begin
                        rvalid1_d = 1'b1;
                        rdata1_d  = readdata;
                    end else begin
                        rvalid0_d = 1'b1;
                        rdata0_d  = readdata;
                    end
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            owner_q <= 1'b0;
`ifdef MEMARB_RR_EN
            last_q  <= 1'b1;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            owner_q <= owner_d;
`ifdef MEMARB_RR_EN
            last_q  <= last_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            read         <= 1'b0;
            write        <= 1'b0;
            m0_ready     <= 1'b0;
            m1_ready     <= 1'b0;
            m0_rvalid    <= 1'b0;
            m1_rvalid    <= 1'b0;
            m0_rdata     <= '0;
            m1_rdata     <= '0;
            readaddress  <= '0;
            writeaddress <= '0;
            writedata    <= '0;
        end else begin
            read         <= read_d;
            write        <= write_d;
            m0_ready     <= ready0_d;
            m1_ready     <= ready1_d;
            m0_rvalid    <= rvalid0_d;
            m1_rvalid    <= rvalid1_d;
            m0_rdata     <= rdata0_d;
            m1_rdata     <= rdata1_d;
            readaddress  <= raddr_d;
            writeaddress <= waddr_d;
            writedata    <= wdata_d;
        end
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: single read, back-to-back writes, contention,
// reset mid-read and read/write interleave. Expectations follow MEMARB_RR_EN when defined.
module tb_mem_port_arbiter;

    localparam int W      = 32;
    localparam int ADDR_W = 32;
    localparam int RD_LAT = 2;

    logic              clk, rst;
    logic              m0_valid, m0_we, m0_ready, m0_rvalid;
    logic [ADDR_W-1:0] m0_addr;
    logic [W-1:0]      m0_wdata, m0_rdata;
    logic              m1_valid, m1_we, m1_ready, m1_rvalid;
    logic [ADDR_W-1:0] m1_addr;
    logic [W-1:0]      m1_wdata, m1_rdata;
    logic              read, write, busy;
    logic [ADDR_W-1:0] readaddress, writeaddress;
    logic [W-1:0]      writedata, readdata;

    int checks = 0;
    int errors = 0;

    mem_port_arbiter #(.W(W), .ADDR_W(ADDR_W), .RD_LAT(RD_LAT)) dut (
        .clk(clk), .rst(rst),
        .m0_valid(m0_valid), .m0_we(m0_we), .m0_addr(m0_addr), .m0_wdata(m0_wdata),
        .m0_ready(m0_ready), .m0_rvalid(m0_rvalid), .m0_rdata(m0_rdata),
        .m1_valid(m1_valid), .m1_we(m1_we), .m1_addr(m1_addr), .m1_wdata(m1_wdata),
        .m1_ready(m1_ready), .m1_rvalid(m1_rvalid), .m1_rdata(m1_rdata),
        .read(read), .write(write), .readaddress(readaddress), .writeaddress(writeaddress),
        .writedata(writedata), .readdata(readdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [W-1:0] mem_fn(input logic [ADDR_W-1:0] a);
        if (a == 32'h40) return 32'hDEADBEEF;
        return 32'hA500_0000 | a;
    endfunction

    // Memory model: data for a read strobed in cycle c is presented in cycle c+RD_LAT only.
    logic              pv [RD_LAT];
    logic [ADDR_W-1:0] pa [RD_LAT];
    always @(posedge clk) begin
        pv[0] <= read;
        pa[0] <= readaddress;
        for (int i = 1; i < RD_LAT; i++) begin
            pv[i] <= pv[i-1];
            pa[i] <= pa[i-1];
        end
    end
    assign readdata = pv[RD_LAT-1] ? mem_fn(pa[RD_LAT-1]) : 32'hBAD0_BAD0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(negedge clk);
    endtask

`ifdef MEMARB_RR_EN
    int exp_gnt [5] = '{0, 1, 0, 1, 0};
    int exp_rv0 = 3;
    int exp_rv1 = 2;
`else
    int exp_gnt [5] = '{0, 0, 0, 0, 1};
    int exp_rv0 = 4;
    int exp_rv1 = 1;
`endif

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int gnt [8];
        int ng, rv0, rv1, cnt, wcnt;
        logic done;
        logic [W-1:0] exp0, exp1;

        rst = 1'b0;
        m0_valid = 1'b0; m0_we = 1'b0; m0_addr = '0; m0_wdata = '0;
        m1_valid = 1'b0; m1_we = 1'b0; m1_addr = '0; m1_wdata = '0;
        repeat (2) step();
        check("rst_strobes", {read, write, m0_ready, m1_ready, m0_rvalid, m1_rvalid, busy}, 0);
        check("rst_rdata", {m0_rdata, m1_rdata}, 0);
        check("rst_addr", {readaddress, writeaddress}, 0);
        check("rst_wdata", writedata, 0);
        rst = 1'b1;
        step();

        // Single m0 read of 0x40
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        step();
        check("rd_strobe", read, 1);
        check("rd_addr", readaddress, 32'h40);
        check("rd_ready0", {m0_ready, m1_ready}, 2'b10);
        check("rd_busy", busy, 1);
        m0_valid = 1'b0;
        step();
        check("rd_strobe_once", {read, m0_ready}, 0);
        for (int c = 2; c < 2 + RD_LAT; c++) begin
            check("rd_no_early_rvalid", m0_rvalid, 0);
            step();
        end
        check("rd_rvalid", m0_rvalid, 1);
        check("rd_rdata", m0_rdata, 32'hDEADBEEF);
        check("rd_m1_untouched", {m1_rvalid, m1_rdata}, 0);
        check("rd_idle", busy, 0);
        step();
        check("rd_rvalid_once", m0_rvalid, 0);
        check("rd_rdata_held", m0_rdata, 32'hDEADBEEF);

        // Back-to-back m1 writes
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h8; m1_wdata = 32'h11;
        step();
        check("wr1_strobe", {write, m1_ready, m0_ready}, 3'b110);
        check("wr1_addr", writeaddress, 32'h8);
        check("wr1_data", writedata, 32'h11);
        check("wr1_not_busy", busy, 0);
        m1_addr = 32'hC; m1_wdata = 32'h22;
        step();
        check("wr_gap", {write, m1_ready}, 0);
        step();
        check("wr2_strobe", {write, m1_ready}, 2'b11);
        check("wr2_addr", writeaddress, 32'hC);
        check("wr2_data", writedata, 32'h22);
        m1_valid = 1'b0; m1_we = 1'b0;
        step();
        check("wr2_once", write, 0);
        check("addr_hold", {readaddress, writeaddress}, {32'h40, 32'hC});

        // Contention: both requesters keep issuing reads until 4 grants, then retire
        ng = 0; rv0 = 0; rv1 = 0; done = 1'b0; exp0 = '0; exp1 = '0;
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h100;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 32'h200;
        step();
        for (int cyc = 0; cyc < 200; cyc++) begin
            if (m0_rvalid) begin
                rv0++;
                check("cont_rdata0", m0_rdata, exp0);
            end
            if (m1_rvalid) begin
                rv1++;
                check("cont_rdata1", m1_rdata, exp1);
            end
            if (m0_ready) begin
                if (ng < 8) gnt[ng] = 0;
                ng++;
                exp0 = mem_fn(m0_addr);
                if (ng >= 4) m0_valid = 1'b0;
                else m0_addr = m0_addr + 32'h4;
            end
            if (m1_ready) begin
                if (ng < 8) gnt[ng] = 1;
                ng++;
                exp1 = mem_fn(m1_addr);
                if (ng >= 4) m1_valid = 1'b0;
                else m1_addr = m1_addr + 32'h4;
            end
            if (!m0_valid && !m1_valid && !busy) begin
                done = 1'b1;
                break;
            end
            step();
        end
        check("cont_done", done, 1);
        check("cont_grants", ng, 5);
        for (int i = 0; i < 5; i++) check($sformatf("cont_grant%0d", i), gnt[i], exp_gnt[i]);
        check("cont_rv0", rv0, exp_rv0);
        check("cont_rv1", rv1, exp_rv1);
        step();

        // Reset in cycle 2 of an m0 read
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h40;
        step();
        check("rstmid_read", read, 1);
        m0_valid = 1'b0;
        step();
        rst = 1'b0;
        #1;
        check("rstmid_busy", busy, 0);
        check("rstmid_rdata0", m0_rdata, 0);
        cnt = 0;
        m1_valid = 1'b1; m1_we = 1'b0; m1_addr = 32'h44;
        repeat (2) begin
            step();
            if (m0_rvalid) cnt++;
            check("rstmid_no_accept", {m1_ready, read}, 0);
        end
        rst = 1'b1;
        step();
        check("rstmid_m1_accept", {read, m1_ready}, 2'b11);
        check("rstmid_m1_addr", readaddress, 32'h44);
        m1_valid = 1'b0;
        for (int c = 2; c <= 2 + RD_LAT; c++) begin
            step();
            if (m0_rvalid) cnt++;
            if (c < 2 + RD_LAT) check("rstmid_m1_early", m1_rvalid, 0);
        end
        check("rstmid_m1_rvalid", m1_rvalid, 1);
        check("rstmid_m1_rdata", m1_rdata, mem_fn(32'h44));
        check("rstmid_no_rvalid0", cnt, 0);
        step();

        // m1 write waits behind an outstanding m0 read
        m0_valid = 1'b1; m0_we = 1'b0; m0_addr = 32'h80;
        m1_valid = 1'b1; m1_we = 1'b1; m1_addr = 32'h90; m1_wdata = 32'h55;
        step();
        check("il_read", {read, m0_ready, write, m1_ready}, 4'b1100);
        m0_valid = 1'b0;
        wcnt = 0;
        for (int c = 2; c <= 2 + RD_LAT; c++) begin
            step();
            if (write || m1_ready) wcnt++;
        end
        check("il_no_early_write", wcnt, 0);
        check("il_rvalid0", m0_rvalid, 1);
        check("il_rdata0", m0_rdata, mem_fn(32'h80));
        step();
        check("il_write", {write, m1_ready}, 2'b11);
        check("il_waddr", writeaddress, 32'h90);
        check("il_wdata", writedata, 32'h55);
        m1_valid = 1'b0; m1_we = 1'b0;
        step();
        check("il_write_once", write, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
